// File: rtl/csr_timer_if.sv
// CSR read/write bus shared between the timer block and the CSR file,
// plus the timer-side status outputs.
interface csr_timer_if;
  logic        csr_re;
  logic [31:0] csr_num;
  logic [3:0]  csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        csr_hit;
  logic [31:0] csr_rvalue;
  logic        timer_int;
  logic [63:0] cnt_value;
  logic [31:0] cnt_id;

  modport master (
    output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
    input  csr_hit, csr_rvalue, timer_int, cnt_value, cnt_id
  );

  modport slave (
    input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
    output csr_hit, csr_rvalue, timer_int, cnt_value, cnt_id
  );
endinterface

// File: rtl/csr_timer.sv
// Timer / stable-counter unit: owns TID, TCFG, TVAL, TICLR and a 64-bit
// free-running counter; drives the registered timer interrupt.
module csr_timer #(
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  logic       clk,
  input  logic       reset,
  csr_timer_if.slave bus
);
  localparam logic [11:0] A_TID   = 12'h040;
  localparam logic [11:0] A_TCFG  = 12'h041;
  localparam logic [11:0] A_TVAL  = 12'h042;
  localparam logic [11:0] A_TICLR = 12'h044;

  logic [11:0] addr;
  logic [31:0] wmask_eff;
  logic        wr_tcfg, clr_ti, tick;
  logic [31:0] reload;
  logic        unused_num;

  logic [31:0] tid_q, tid_d;
  logic [31:0] tcfg_q, tcfg_d;
  logic [31:0] tval_q, tval_d;
  logic        armed_q, armed_d;
  logic        ti_q, ti_d;
  logic [63:0] cnt_q;

  assign addr       = bus.csr_num[11:0];
  assign unused_num = ^bus.csr_num[31:12];

  // A bit is writable only when both its byte lane and its mask bit are set.
  assign wmask_eff = bus.csr_wmask & {{8{bus.csr_we[3]}}, {8{bus.csr_we[2]}},
                                      {8{bus.csr_we[1]}}, {8{bus.csr_we[0]}}};

  // Any lane enable at the TCFG address counts as a TCFG write, even if the
  // mask leaves the value unchanged: it still re-arms (or freezes) the timer.
  assign wr_tcfg = (addr == A_TCFG) && (|bus.csr_we);
  assign clr_ti  = (addr == A_TICLR) && wmask_eff[0] && bus.csr_wvalue[0];

  // Register write merge for TID and TCFG.
  always_comb begin
    tid_d  = tid_q;
    tcfg_d = tcfg_q;
    if (addr == A_TID)  tid_d  = (tid_q  & ~wmask_eff) | (bus.csr_wvalue & wmask_eff);
    if (addr == A_TCFG) tcfg_d = (tcfg_q & ~wmask_eff) | (bus.csr_wvalue & wmask_eff);
  end

  // Reload comes from the post-write TCFG so a write arms with its own InitVal.
  assign reload = {tcfg_d[31:2], 2'b00};
  // A TCFG write in the expiry cycle takes over: the tick is dropped entirely.
  assign tick   = tcfg_q[0] && armed_q && (tval_q == 32'h0) && !wr_tcfg;

  // Countdown / re-arm / interrupt-pending next state.
  always_comb begin
    tval_d  = tval_q;
    armed_d = armed_q;
    ti_d    = ti_q;
    if (wr_tcfg) begin
      if (tcfg_d[0]) begin
        tval_d  = reload;
        armed_d = 1'b1;
      end
    end else if (tick) begin
      if (tcfg_q[1]) begin
        tval_d = reload;
      end else begin
        tval_d  = 32'hFFFF_FFFF;
        armed_d = 1'b0;
      end
    end else if (tcfg_q[0] && armed_q) begin
      tval_d = tval_q - 32'd1;
    end
    if (tick)        ti_d = 1'b1;
    else if (clr_ti) ti_d = 1'b0;
  end

  // State registers; reset wins over any write or tick in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tid_q   <= TID_RESET;
      tcfg_q  <= 32'h0;
      tval_q  <= 32'hFFFF_FFFF;
      armed_q <= 1'b0;
      ti_q    <= 1'b0;
      cnt_q   <= 64'h0;
    end else begin
      tid_q   <= tid_d;
      tcfg_q  <= tcfg_d;
      tval_q  <= tval_d;
      armed_q <= armed_d;
      ti_q    <= ti_d;
      cnt_q   <= cnt_q + 64'd1;
    end
  end

  // Address decode and combinational read mux; TICLR reads as zero.
  always_comb begin
    bus.csr_hit    = 1'b0;
    bus.csr_rvalue = 32'h0;
    case (addr)
      A_TID:   begin bus.csr_hit = 1'b1; if (bus.csr_re) bus.csr_rvalue = tid_q;  end
      A_TCFG:  begin bus.csr_hit = 1'b1; if (bus.csr_re) bus.csr_rvalue = tcfg_q; end
      A_TVAL:  begin bus.csr_hit = 1'b1; if (bus.csr_re) bus.csr_rvalue = tval_q; end
      A_TICLR: bus.csr_hit = 1'b1;
      default: ;
    endcase
  end

  assign bus.timer_int = ti_q;
  assign bus.cnt_value = cnt_q;
  assign bus.cnt_id    = tid_q;
endmodule

// File: tb/tb_csr_timer.sv
// Self-checking bench for csr_timer: directed scenarios plus a randomized
// run, all checked against a cycle-level behavioural model of the CSR rules.
module tb_csr_timer;
  localparam logic [31:0] TID_R = 32'hA5C3_0001;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  csr_timer_if bus();
  csr_timer #(.TID_RESET(TID_R)) dut (.clk(clk), .reset(rst), .bus(bus));

  // behavioural model state
  logic [31:0] m_tid, m_tcfg, m_tval;
  logic        m_armed, m_ti;
  logic [63:0] m_cnt;

  task automatic set_in(input logic re, input logic [31:0] num, input logic [3:0] we,
                        input logic [31:0] mask, input logic [31:0] wv);
    bus.csr_re     = re;
    bus.csr_num    = num;
    bus.csr_we     = we;
    bus.csr_wmask  = mask;
    bus.csr_wvalue = wv;
  endtask

  task automatic rd(input logic [31:0] num);
    set_in(1'b1, num, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] num, input logic [31:0] wv);
    set_in(1'b0, num, 4'hF, 32'hFFFF_FFFF, wv);
  endtask

  function automatic logic exp_hit();
    int a;
    a = int'(bus.csr_num[11:0]);
    return (a == 'h40) || (a == 'h41) || (a == 'h42) || (a == 'h44);
  endfunction

  function automatic logic [31:0] exp_rd();
    if (!bus.csr_re || !exp_hit()) return 32'h0;
    case (bus.csr_num[11:0])
      12'h040: return m_tid;
      12'h041: return m_tcfg;
      12'h042: return m_tval;
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge: advance the model from the rules using the held inputs.
  task automatic adv();
    logic [31:0] m, ncfg, rl;
    logic        wcfg, tk;
    @(posedge clk);
    if (rst) begin
      m_tid = TID_R; m_tcfg = 0; m_tval = 32'hFFFF_FFFF;
      m_armed = 0; m_ti = 0; m_cnt = 0;
    end else begin
      for (int i = 0; i < 32; i++) m[i] = bus.csr_wmask[i] & bus.csr_we[i/8];
      m_cnt = m_cnt + 1;
      if (bus.csr_num[11:0] == 12'h040) m_tid = (m_tid & ~m) | (bus.csr_wvalue & m);
      wcfg = (bus.csr_num[11:0] == 12'h041) && (bus.csr_we != 0);
      ncfg = (bus.csr_num[11:0] == 12'h041) ? ((m_tcfg & ~m) | (bus.csr_wvalue & m)) : m_tcfg;
      rl   = ncfg & 32'hFFFF_FFFC;
      tk   = m_tcfg[0] && m_armed && (m_tval == 0) && !wcfg;
      if (wcfg) begin
        if (ncfg[0]) begin m_tval = rl; m_armed = 1; end
      end else if (tk) begin
        if (m_tcfg[1]) m_tval = rl;
        else begin m_tval = 32'hFFFF_FFFF; m_armed = 0; end
      end else if (m_tcfg[0] && m_armed) begin
        m_tval = m_tval - 1;
      end
      if (tk) m_ti = 1;
      else if (bus.csr_num[11:0] == 12'h044 && m[0] && bus.csr_wvalue[0]) m_ti = 0;
      m_tcfg = ncfg;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] addrs [5];
    logic [31:0] expv  [5];
    addrs = '{32'h040, 32'h041, 32'h042, 32'h044, 32'h050};
    expv  = '{TID_R, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0);
    adv(); adv();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd(addrs[i]);
      @(negedge clk);
      total++;
      if (bus.csr_rvalue !== expv[i]) begin
        bad++; $display("FAIL reset_read addr=%h got=%h exp=%h", addrs[i], bus.csr_rvalue, expv[i]);
      end
      total++;
      if (bus.csr_hit !== (i < 4)) begin
        bad++; $display("FAIL reset_hit addr=%h got=%b exp=%b", addrs[i], bus.csr_hit, i < 4);
      end
      total++;
      if (bus.timer_int !== 1'b0 || bus.cnt_value !== 64'(i)) begin
        bad++; $display("FAIL reset_state ti=%b cnt=%0d exp ti=0 cnt=%0d", bus.timer_int, bus.cnt_value, i);
      end
      adv();
    end
  endtask

  task automatic test_oneshot();
    int rise = -1;
    wr(32'h041, 32'h0000_0011);
    adv();
    for (int t = 0; t < 40; t++) begin
      rd(32'h042);
      @(negedge clk);
      total++;
      if (bus.csr_rvalue !== ((t <= 16) ? 32'(16 - t) : 32'hFFFF_FFFF)) begin
        bad++; $display("FAIL oneshot_tval t=%0d got=%h model=%h", t, bus.csr_rvalue, m_tval);
      end
      if (bus.timer_int === 1'b1) rise = t;
      adv();
      if (rise >= 0) break;
    end
    total++;
    if (rise != 17) begin
      bad++; $display("FAIL oneshot_latency got=%0d exp=17", rise);
    end
    for (int t = 0; t < 5; t++) begin
      rd(32'h042);
      @(negedge clk);
      total++;
      if (bus.csr_rvalue !== 32'hFFFF_FFFF || bus.timer_int !== 1'b1) begin
        bad++; $display("FAIL oneshot_hold tval=%h ti=%b exp FFFFFFFF/1", bus.csr_rvalue, bus.timer_int);
      end
      adv();
    end
    wr(32'h044, 32'h1);
    adv();
    for (int t = 0; t < 20; t++) begin
      rd(32'h042);
      @(negedge clk);
      total++;
      if (bus.timer_int !== 1'b0) begin
        bad++; $display("FAIL oneshot_noretrigger t=%0d ti=%b exp=0", t, bus.timer_int);
      end
      adv();
    end
  endtask

  task automatic test_periodic();
    wr(32'h041, 32'h0000_000B);
    adv();
    for (int t = 0; t < 27; t++) begin
      rd(32'h042);
      @(negedge clk);
      total++;
      if (bus.csr_rvalue !== 32'(8 - t % 9)) begin
        bad++; $display("FAIL periodic_tval t=%0d got=%h exp=%h", t, bus.csr_rvalue, 32'(8 - t % 9));
      end
      total++;
      if (bus.timer_int !== (t >= 9 && t % 9 == 0)) begin
        bad++; $display("FAIL periodic_ti t=%0d got=%b exp=%b", t, bus.timer_int, (t >= 9 && t % 9 == 0));
      end
      if (bus.timer_int === 1'b1) wr(32'h044, 32'h1);
      adv();
    end
  endtask

  task automatic test_simultaneous();
    wr(32'h041, 32'h0000_0003);
    adv();
    for (int t = 0; t < 10; t++) begin
      wr(32'h044, 32'h1);
      @(negedge clk);
      total++;
      if (bus.timer_int !== m_ti || (t >= 1 && bus.timer_int !== 1'b1)) begin
        bad++; $display("FAIL setwins t=%0d ti=%b exp=1", t, bus.timer_int);
      end
      adv();
    end
    wr(32'h041, 32'h0000_000B);
    adv();
    wr(32'h044, 32'h1);
    adv();
    for (int t = 1; t <= 10; t++) begin
      rd(32'h042);
      @(negedge clk);
      total++;
      if (bus.csr_rvalue !== ((t <= 8) ? 32'(8 - t) : 32'(17 - t)) || bus.timer_int !== 1'b0) begin
        bad++; $display("FAIL rewrite_at_zero t=%0d tval=%h ti=%b model_tval=%h exp_ti=0",
                        t, bus.csr_rvalue, bus.timer_int, m_tval);
      end
      if (t == 8) wr(32'h041, 32'h0000_000B);
      adv();
    end
  endtask

  task automatic test_masking();
    logic [31:0] held;
    wr(32'h041, 32'h0);
    adv();
    wr(32'h040, 32'h0);
    adv();
    set_in(0, 32'h040, 4'b0010, 32'h0000_F0F0, 32'hFFFF_FFFF);
    adv();
    rd(32'h040);
    @(negedge clk);
    total++;
    if (bus.csr_rvalue !== 32'h0000_F000 || bus.cnt_id !== 32'h0000_F000) begin
      bad++; $display("FAIL mask_tid got=%h id=%h exp=0000F000", bus.csr_rvalue, bus.cnt_id);
    end
    adv();
    held = m_tval;
    wr(32'h042, $urandom);
    adv();
    rd(32'h042);
    @(negedge clk);
    total++;
    if (bus.csr_rvalue !== held) begin
      bad++; $display("FAIL tval_readonly got=%h exp=%h", bus.csr_rvalue, held);
    end
    adv();
  endtask

  task automatic test_random();
    logic [31:0] atab [6];
    logic [31:0] a, wv;
    atab = '{32'h040, 32'h041, 32'h042, 32'h044, 32'h050, 32'h041};
    for (int c = 0; c < 400; c++) begin
      a = atab[$urandom_range(0, 5)] | ($urandom_range(0, 3) == 0 ? {$urandom_range(0, 15), 12'h0} : 32'h0);
      wv = (a[11:0] == 12'h041) ? ((32'($urandom_range(0, 6)) << 2) | 32'($urandom_range(0, 3))) : $urandom;
      if ($urandom_range(0, 9) < 3)
        set_in($urandom_range(0, 1), a, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
               $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom, wv);
      else
        set_in($urandom_range(0, 3) != 0, a, 4'h0, $urandom, wv);
      @(negedge clk);
      total++;
      if (bus.csr_rvalue !== exp_rd() || bus.csr_hit !== exp_hit()) begin
        bad++; $display("FAIL rand_read c=%0d a=%h got=%h/%b exp=%h/%b", c, a, bus.csr_rvalue, bus.csr_hit, exp_rd(), exp_hit());
      end
      total++;
      if (bus.timer_int !== m_ti || bus.cnt_id !== m_tid || bus.cnt_value !== m_cnt) begin
        bad++; $display("FAIL rand_state c=%0d ti=%b id=%h cnt=%0d exp %b %h %0d",
                        c, bus.timer_int, bus.cnt_id, bus.cnt_value, m_ti, m_tid, m_cnt);
      end
      adv();
    end
  endtask

  task automatic test_counter_reset();
    logic [63:0] base;
    rd(32'h050);
    @(negedge clk);
    base = m_cnt;
    adv();
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      total++;
      if (bus.cnt_value !== base + 64'(t)) begin
        bad++; $display("FAIL cnt_incr t=%0d got=%0d exp=%0d", t, bus.cnt_value, base + 64'(t));
      end
      adv();
    end
    wr(32'h041, 32'h0000_0003);
    adv(); adv(); adv();
    rd(32'h050);
    @(negedge clk);
    total++;
    if (bus.timer_int !== 1'b1) begin
      bad++; $display("FAIL pre_reset_ti got=%b exp=1", bus.timer_int);
    end
    rst = 1'b1;
    adv();
    rst = 1'b0;
    rd(32'h040);
    @(negedge clk);
    total++;
    if (bus.cnt_value !== 64'h0 || bus.timer_int !== 1'b0 || bus.csr_rvalue !== TID_R) begin
      bad++; $display("FAIL midrun_reset cnt=%0d ti=%b tid=%h exp 0/0/%h", bus.cnt_value, bus.timer_int, bus.csr_rvalue, TID_R);
    end
    adv();
    @(negedge clk);
    total++;
    if (bus.cnt_value !== 64'h1) begin
      bad++; $display("FAIL cnt_after_reset got=%0d exp=1", bus.cnt_value);
    end
    adv();
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0);
    test_reset();
    test_oneshot();
    test_periodic();
    test_simultaneous();
    test_masking();
    test_random();
    test_counter_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/csr_timer.md
# csr_timer

Timer and stable-counter unit that sits directly upstream of the CSR file. It owns the TID, TCFG, TVAL and TICLR CSRs and a free-running 64-bit stable counter. Its registered `timer_int` output drives the CSR file's `timer_int` input, which sets ESTAT.IS[11]. It shares the CSR read/write bus with the CSR file; `csr_hit` tells the pipeline which of the two blocks supplies the read data.

## Interface
- `TID_RESET`, default 32'h0: reset value of TID.
- `clk` input 1: clock.
- `reset` input 1: reset; synchronous, active-high.
- `csr_re` input 1: CSR read enable.
- `csr_num` input 32: CSR address; only [11:0] is decoded.
- `csr_we` input 4: byte-lane write enables.
- `csr_wmask` input 32: bit write mask.
- `csr_wvalue` input 32: write data.
- `csr_hit` output 1: `csr_num[11:0]` is one of 0x040, 0x041, 0x042, 0x044.
- `csr_rvalue` output 32: read data, combinational.
- `timer_int` output 1: timer interrupt pending (TI), registered.
- `cnt_value` output 64: stable counter, for rdcnt.
- `cnt_id` output 32: current TID value.

## Operation
CSR map:
- 0x040 TID: read/write, all 32 bits.
- 0x041 TCFG: read/write. Bit 0 is En, bit 1 is Periodic, bits [31:2] are InitVal.
- 0x042 TVAL: read-only. Writes are ignored.
- 0x044 TICLR: write-1-to-clear on bit 0. Reads return 0.

Write rule, per bit i:
- A bit is written iff `csr_we[i/8]` and `csr_wmask[i]` are both set.
- The new value is `(old & ~mask) | (wvalue & mask)`, applied lane by lane.

Reads:
- `csr_rvalue = (csr_re && csr_hit) ? reg : 0`.
- TICLR reads 0.

Stable counter:
- 64 bits, increments by 1 every cycle after reset.
- Wraps from 2^64-1 to 0.
- Not writable.

Timer state:
- `tval` (32 bits), `armed` (1 bit), `ti` (1 bit).
- `reload = {TCFG.InitVal, 2'b00}`, computed from the post-write TCFG value.
- `tick = TCFG.En && armed && (tval == 0)`.

Per-cycle update of `tval`/`armed`, in priority order:
1. TCFG write whose resulting En = 1: `tval <= reload`, `armed <= 1`. Any tick in the same cycle is suppressed.
2. TCFG write whose resulting En = 0: `tval` holds, `armed` holds.
3. `tick` with Periodic = 1: `tval <= reload`.
4. `tick` with Periodic = 0: `tval <= 32'hFFFF_FFFF`, `armed <= 0`. The timer stops until TCFG is rewritten with En = 1.
5. En && armed && `tval != 0`: `tval <= tval - 1`.
6. Otherwise `tval` holds.

`ti` update:
- A tick sets `ti`.
- A TICLR write with bit 0 effectively written as 1 clears `ti`.
- If both happen in the same cycle, set wins.

Outputs:
- `timer_int = ti`.
- `cnt_id = TID`.

Periodic with InitVal = 0: `reload = 0`, so the timer ticks every cycle while enabled.

## Timing
Reset values:
- TID = `TID_RESET`.
- TCFG = 0.
- `tval` = 32'hFFFF_FFFF.
- `armed` = 0, `ti` = 0, `timer_int` = 0.
- Stable counter = 0; `cnt_value` = 0 in the first cycle after reset deasserts.
- `csr_hit` and `csr_rvalue` are combinational from their inputs.

Latency:
- All CSR writes become visible to reads on the cycle after the write edge.
- Writing TCFG with En = 1 at edge E gives TVAL = reload after E. The count then decreases by 1 per cycle.
- A tick occurs in the cycle where `tval == 0`. `timer_int` rises at the next edge, i.e. reload+1 cycles after the arming write's edge.
- A TICLR write clears `timer_int` at the next edge.

Reset asserted mid-count forces every reset value at that edge. It overrides any write or tick in the same cycle.

## Test plan
1. Reset, then read: TID = `TID_RESET`, TCFG = 0, TVAL = FFFF_FFFF, `timer_int` = 0. Read 0x044 gives 0. Read 0x050 gives `csr_hit` = 0 and data 0.
2. One-shot: write TCFG = 0x0000_0011 (InitVal = 4, reload = 16, En = 1).
   - `timer_int` rises exactly 17 cycles after the write edge.
   - TVAL then reads FFFF_FFFF and holds.
   - No second interrupt after clearing with TICLR = 1.
3. Periodic: write TCFG = 0x0000_000B (reload = 8).
   - Clear TI after each interrupt.
   - Interrupts rise every 9 cycles. TVAL sequence is 8..0, 8..0.
4. Simultaneous events: with periodic reload = 0, write TICLR = 1 every cycle; `timer_int` stays 1 (set wins). Separately, rewrite TCFG in the cycle where `tval == 0`: no interrupt occurs and TVAL reloads.
5. Masking: TID = 0; write `wvalue` = FFFF_FFFF, `we` = 4'b0010, `wmask` = 0000_F0F0. TID reads 0000_F000. A TVAL write leaves TVAL unchanged.
6. Stable counter: `cnt_value` increments by 1 per cycle. A reset asserted mid-run with a pending interrupt zeroes the counter and drops `timer_int` at that edge.
